pwl_mixer_dac: RTL

Downstream stage of the PWL synth ALU (mc_alu_unit). Once per sample period it reads each channel's signed oscillator value and 6-bit amplitude (amps[k]), one channel per cycle. It multiplies and accumulates them, then scales and saturates the sum into one signed mix sample. A first-order sigma-delta modulator turns that held sample into a 1-bit PDM audio output on every clock.

---
 rtl/pwl_synth_pkg.sv | 14 +
 rtl/pwl_sigma_delta.sv | 34 +++
 rtl/pwl_mixer_dac.sv | 124 ++++++++++++
 3 files changed

// File: rtl/pwl_synth_pkg.sv
// Shared definitions for the PWL synth mixer/DAC stage: sequencer states and default widths.
package pwl_synth_pkg;

    localparam int unsigned OSC_BITS = 10;
    localparam int unsigned AMP_BITS = 6;
    localparam int unsigned OUT_BITS = 12;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StLoad
    } state_e;

endpackage

// File: rtl/pwl_sigma_delta.sv
// First-order sigma-delta modulator: turns a signed sample into a 1-bit PDM stream.
module pwl_sigma_delta #(
    parameter int unsigned OUT_BITS = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OUT_BITS-1:0] sample,
    output logic                pdm
);

    logic [OUT_BITS-1:0] u;
    logic [OUT_BITS-1:0] sd_q, sd_d;
    logic                carry;
    logic                pdm_q;

    always_comb begin
        // Flipping the sign bit converts two's complement to offset binary.
        u = {~sample[OUT_BITS-1], sample[OUT_BITS-2:0]};
        {carry, sd_d} = {1'b0, sd_q} + {1'b0, u};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sd_q  <= '0;
            pdm_q <= 1'b0;
        end else begin
            sd_q  <= sd_d;
            pdm_q <= carry;
        end
    end

    assign pdm = pdm_q;

endmodule

// File: rtl/pwl_mixer_dac.sv
// Per-frame multiply-accumulate of all channels into one saturated mix sample,
// held and fed to a sigma-delta PDM output.
module pwl_mixer_dac #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned OSC_BITS = pwl_synth_pkg::OSC_BITS,
    parameter int unsigned AMP_BITS = pwl_synth_pkg::AMP_BITS,
    parameter int unsigned OUT_BITS = pwl_synth_pkg::OUT_BITS,
    parameter int unsigned SHIFT    = 6,
    parameter int unsigned PERIOD   = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    output logic [$clog2(NUM_CH)-1:0] ch_sel,
    input  logic [OSC_BITS-1:0]       osc_in,
    input  logic [AMP_BITS-1:0]       amp_in,
    output logic                      busy,
    output logic [OUT_BITS-1:0]       sample_out,
    output logic                      sample_strobe,
    output logic                      pdm_out
);

    import pwl_synth_pkg::*;

    localparam int unsigned CH_W   = $clog2(NUM_CH);
    localparam int unsigned PROD_W = OSC_BITS + AMP_BITS;
    localparam int unsigned ACC_W  = PROD_W + CH_W;
    localparam int unsigned CNT_W  = $clog2(PERIOD);

    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 << (OUT_BITS - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [CH_W-1:0]           ch_q, ch_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [OUT_BITS-1:0]       sample_q, mix_sat;
    logic                      load_en;

    logic signed [PROD_W-1:0]  osc_ext, amp_ext, prod;
    logic signed [ACC_W-1:0]   acc_sum, acc_shr;

    // Datapath: product, running sum, scaled and clamped mix.
    always_comb begin
        osc_ext = {{AMP_BITS{osc_in[OSC_BITS-1]}}, osc_in};
        amp_ext = {{OSC_BITS{1'b0}}, amp_in};
        prod    = osc_ext * amp_ext;
        acc_sum = acc_q + {{CH_W{prod[PROD_W-1]}}, prod};
        acc_shr = acc_sum >>> SHIFT;
        if (acc_shr > SAT_HI) begin
            mix_sat = {1'b0, {(OUT_BITS - 1){1'b1}}};
        end else if (acc_shr < SAT_LO) begin
            mix_sat = {1'b1, {(OUT_BITS - 1){1'b0}}};
        end else begin
            mix_sat = acc_shr[OUT_BITS-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        acc_d   = acc_q;
        load_en = 1'b0;
        cnt_d   = '0;
        if (enable) begin
            cnt_d = (cnt_q == CNT_W'(PERIOD - 1)) ? '0 : cnt_q + 1'b1;
        end
        case (state_q)
            StIdle: begin
                if (enable && cnt_q == '0) begin
                    state_d = StAccum;
                    acc_d   = '0;
                    ch_d    = '0;
                end
            end
            StAccum: begin
                acc_d = acc_sum;
                if (ch_q == CH_W'(NUM_CH - 1)) begin
                    // Saturated result is captured here so it is visible during LOAD.
                    state_d = StLoad;
                    ch_d    = '0;
                    load_en = 1'b1;
                end else begin
                    ch_d = ch_q + 1'b1;
                end
            end
            StLoad:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            ch_q     <= '0;
            acc_q    <= '0;
            sample_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            acc_q   <= acc_d;
            if (load_en) begin
                sample_q <= mix_sat;
            end
        end
    end

    assign ch_sel        = ch_q;
    assign busy          = (state_q == StAccum);
    assign sample_strobe = (state_q == StLoad);
    assign sample_out    = sample_q;

    pwl_sigma_delta #(
        .OUT_BITS(OUT_BITS)
    ) u_sigma_delta (
        .clk   (clk),
        .reset (reset),
        .sample(sample_q),
        .pdm   (pdm_out)
    );

endmodule
